// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry defaults, FSM states and command opcodes.
package spi_pkg;

  localparam int unsigned DEF_FRAME_W = 10;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    SHIFT,
    WAIT,
    RECV,
    END
  } state_t;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_t;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for spi_master: parallel-load TX shifter, MSB-first RX shifter and the shared bit counter.
module spi_master_shifter
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W = DEF_FRAME_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               tx_shift,
  input  logic               rx_shift,
  input  logic               miso,
  input  logic               cnt_load,
  input  logic [CNT_W-1:0]   cnt_init,
  input  logic               cnt_dec,
  output logic               tx_msb,
  output logic [DATA_W-1:0]  rx_next,
  output logic               cnt_zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [FRAME_W-1:0] tx;
  // Only DATA_W-1 bits are stored; the final bit comes straight from miso at capture time.
  logic [DATA_W-2:0]  rx;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx  <= '0;
      rx  <= '0;
      cnt <= '0;
    end else begin
      if (load)
        tx <= load_data;
      else if (tx_shift)
        tx <= {tx[FRAME_W-2:0], 1'b0};

      if (rx_shift)
        rx <= rx_next[DATA_W-2:0];

      if (cnt_load)
        cnt <= cnt_init;
      else if (cnt_dec)
        cnt <= cnt - CNT_ONE;
    end
  end

  assign tx_msb   = tx[FRAME_W-1];
  assign rx_next  = {rx, miso};
  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI master: serialises host command words into SS_n-framed transactions, captures RD_DATA responses.
// Optional abort input enabled by defining SPI_MASTER_ABORT_EN.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W = DEF_FRAME_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RD_WAIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_data,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic               abort
`endif
);

  state_t             state;
  opcode_t            op;
  logic               accept;
  logic               kill;
  logic               tx_shift;
  logic               rx_shift;
  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_init;
  logic               tx_msb;
  logic [DATA_W-1:0]  rx_next;
  logic               cnt_zero;

  assign accept   = cmd_valid && cmd_ready;
  assign rx_shift = (state == RECV);

`ifdef SPI_MASTER_ABORT_EN
  assign kill = abort && (state != IDLE) && (state != END);
`else
  assign kill = 1'b0;
`endif

  // Counter is reloaded on the edge entering each counted state, so it reads N-1 on the first cycle there.
  always_comb begin
    tx_shift = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_init = '0;
    case (state)
      CMD: begin
        tx_shift = 1'b1;
        cnt_load = 1'b1;
        cnt_init = CNT_W'(FRAME_W - 1);
      end
      SHIFT: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_init = CNT_W'(RD_WAIT - 1);
        end else begin
          tx_shift = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_init = CNT_W'(DATA_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RECV:    cnt_dec = !cnt_zero;
      default: ;
    endcase
  end

  spi_master_shifter #(
    .FRAME_W (FRAME_W),
    .DATA_W  (DATA_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (cmd_data),
    .tx_shift  (tx_shift),
    .rx_shift  (rx_shift),
    .miso      (MISO),
    .cnt_load  (cnt_load),
    .cnt_init  (cnt_init),
    .cnt_dec   (cnt_dec),
    .tx_msb    (tx_msb),
    .rx_next   (rx_next),
    .cnt_zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op        <= WR_ADDR;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
      if (kill) begin
        state <= END;
        SS_n  <= 1'b1;
        MOSI  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state     <= START;
              op        <= opcode_t'(cmd_data[FRAME_W-1 -: 2]);
              SS_n      <= 1'b0;
              MOSI      <= 1'b0;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end
          end
          START: begin
            state <= CMD;
            MOSI  <= tx_msb;
          end
          CMD: begin
            state <= SHIFT;
            MOSI  <= tx_msb;
          end
          SHIFT: begin
            if (cnt_zero) begin
              MOSI <= 1'b0;
              if (op == RD_DATA) begin
                state <= WAIT;
              end else begin
                state <= END;
                SS_n  <= 1'b1;
              end
            end else begin
              MOSI <= tx_msb;
            end
          end
          WAIT: begin
            if (cnt_zero)
              state <= RECV;
          end
          RECV: begin
            if (cnt_zero) begin
              state    <= END;
              SS_n     <= 1'b1;
              rd_data  <= rx_next;
              rd_valid <= 1'b1;
            end
          end
          END: begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master; includes an abort scenario when SPI_MASTER_ABORT_EN is defined.
module tb_spi_master;

  localparam int unsigned RD_WAIT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_master #(
    .FRAME_W (10),
    .DATA_W  (8),
    .RD_WAIT (RD_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
`ifdef SPI_MASTER_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one frame starting at a negedge; returns at the negedge of the END cycle.
  // Plays the slave: drives resp MSB first in the RECV window and 1s elsewhere in the frame.
  task automatic run_frame(input logic [9:0] cmd, input logic [7:0] resp,
                           output int low, output logic [11:0] mosi_bits,
                           output int rv_cnt, output logic rdy_bad, output logic busy_bad);
    logic done;
    int   k;
    low = 0; mosi_bits = '0; rv_cnt = 0; rdy_bad = 1'b0; busy_bad = 1'b0; done = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = '0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (rd_valid)  rv_cnt++;
      if (cmd_ready) rdy_bad = 1'b1;
      if (!busy)     busy_bad = 1'b1;
      if (SS_n) begin
        done = 1'b1;
      end else begin
        if (low < 12) mosi_bits[11-low] = MOSI;
        k = low - 12 - int'(RD_WAIT);
        MISO = (k >= 0 && k < 8) ? resp[7-k] : 1'b1;
        low++;
        @(negedge clk);
      end
    end
    MISO = 1'b0;
    check_eq("frame_end", 32'(done), 32'd1);
  endtask

  task automatic post_frame(input string tag);
    @(negedge clk);
    check_eq({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_busy_after"},  32'(busy),      32'd0);
    check_eq({tag, "_rv_after"},    32'(rd_valid),  32'd0);
  endtask

  int          low, rv;
  logic [11:0] mb;
  logic        rb, bb;
  logic [26:0] ss_tr;
  logic [9:0]  b_bits;
  logic        rdy_end, rdy_idle;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; MISO = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ss_n",  32'(SS_n),      32'd1);
    check_eq("rst_mosi",  32'(MOSI),      32'd0);
    check_eq("rst_rdata", 32'(rd_data),   32'h00);
    check_eq("rst_rv",    32'(rd_valid),  32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);

    // WR_ADDR 0x0A5: MOSI 0(start),0(cmd),0,0,1,0,1,0,0,1,0,1
    run_frame(10'h0A5, 8'h00, low, mb, rv, rb, bb);
    check_eq("wra_low",   32'(low), 32'd12);
    check_eq("wra_mosi",  32'(mb),  32'h0A5);
    check_eq("wra_rx",    32'(mb[9:0]), 32'h0A5);
    check_eq("wra_rv",    32'(rv),  32'd0);
    check_eq("wra_busy",  32'(bb),  32'd0);
    post_frame("wra");

    // WR_DATA 0x13C: cmd bit 9 is 0, so MOSI = 0,0,01_0011_1100
    run_frame(10'h13C, 8'h00, low, mb, rv, rb, bb);
    check_eq("wrd_low",   32'(low), 32'd12);
    check_eq("wrd_mosi",  32'(mb),  32'h13C);
    check_eq("wrd_ready_in_frame", 32'(rb), 32'd0);
    check_eq("wrd_rv",    32'(rv),  32'd0);
    post_frame("wrd");

    // Reset on the sixth frame cycle of an RD_DATA frame whose MOSI is all ones there
    cmd_valid = 1'b1; cmd_data = 10'h3FF;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_ss_n",  32'(SS_n),     32'd1);
    check_eq("rstmid_mosi",  32'(MOSI),     32'd0);
    check_eq("rstmid_rv",    32'(rd_valid), 32'd0);
    check_eq("rstmid_rdata", 32'(rd_data),  32'h00);
    check_eq("rstmid_busy",  32'(busy),     32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstmid_ready", 32'(cmd_ready), 32'd1);
    check_eq("rstmid_rv2",   32'(rd_valid),  32'd0);

    // RD_ADDR 0x2AB: no wait/receive phase; MOSI = 0,1,10_1010_1011
    run_frame(10'h2AB, 8'hFF, low, mb, rv, rb, bb);
    check_eq("rda_low",   32'(low),     32'd12);
    check_eq("rda_mosi",  32'(mb),      32'h6AB);
    check_eq("rda_rv",    32'(rv),      32'd0);
    check_eq("rda_rdata", 32'(rd_data), 32'h00);
    post_frame("rda");

    // RD_DATA 0x300 with slave response 0xC3: 12 + 2 + 8 = 22 cycles low
    run_frame(10'h300, 8'hC3, low, mb, rv, rb, bb);
    check_eq("rdd_low",   32'(low),     32'd22);
    check_eq("rdd_mosi",  32'(mb),      32'h700);
    check_eq("rdd_rv",    32'(rv),      32'd1);
    check_eq("rdd_rdata", 32'(rd_data), 32'hC3);
    check_eq("rdd_busy",  32'(bb),      32'd0);
    post_frame("rdd");
    check_eq("rdd_hold",  32'(rd_data), 32'hC3);

    // Second read exercising both end bits of the response
    run_frame(10'h3FF, 8'h81, low, mb, rv, rb, bb);
    check_eq("rdd2_low",   32'(low),     32'd22);
    check_eq("rdd2_mosi",  32'(mb),      32'h7FF);
    check_eq("rdd2_rdata", 32'(rd_data), 32'h81);
    post_frame("rdd2");

    // Back-to-back: cmd_valid held. Frame gap is END plus the accepting IDLE cycle.
    cmd_valid = 1'b1; cmd_data = 10'h055;
    @(negedge clk);
    cmd_data = 10'h1F0;
    rdy_end = 1'b1; rdy_idle = 1'b0; b_bits = '0;
    for (int i = 0; i < 27; i++) begin
      ss_tr[i] = SS_n;
      if (i >= 16 && i <= 25) b_bits[25-i] = MOSI;
      if (i == 12) rdy_end  = cmd_ready;
      if (i == 13) rdy_idle = cmd_ready;
      if (i == 14) begin cmd_valid = 1'b0; cmd_data = '0; end
      @(negedge clk);
    end
    check_eq("b2b_ss_trace", 32'(ss_tr),  32'h4003000);
    check_eq("b2b_second",   32'(b_bits), 32'h1F0);
    check_eq("b2b_ready_end",  32'(rdy_end),  32'd0);
    check_eq("b2b_ready_idle", 32'(rdy_idle), 32'd1);
    check_eq("b2b_ready_after", 32'(cmd_ready), 32'd1);

`ifdef SPI_MASTER_ABORT_EN
    // Abort in the fourth RECV cycle of an RD_DATA frame; rd_data keeps 0x81
    cmd_valid = 1'b1; cmd_data = 10'h3FF;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = '0;
    for (int i = 0; i < 17; i++) begin
      MISO = (i >= 14) ? ((i % 2) == 0) : 1'b1;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    MISO  = 1'b0;
    check_eq("abt_ss_n",  32'(SS_n),     32'd1);
    check_eq("abt_mosi",  32'(MOSI),     32'd0);
    check_eq("abt_rv",    32'(rd_valid), 32'd0);
    check_eq("abt_rdata", 32'(rd_data),  32'h81);
    check_eq("abt_ready_end", 32'(cmd_ready), 32'd0);
    post_frame("abt");
    check_eq("abt_rdata_hold", 32'(rd_data), 32'h81);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
